wb_sdram_arbiter: RTL and testbench

Round-robin Wishbone B4 arbiter that shares the single SDRAM controller slave port between several bus masters (CPU instruction bus, CPU data bus, DMA). Sits between the SoC masters and the SDRAM controller's Wishbone port, in the Wishbone clock domain. It holds a grant for the whole `cyc` envelope so registered bursts (`cti`/`bte`) reach the controller intact. A compile-time watchdog can terminate stalled cycles with `err`.

---
 rtl/wb_sdram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter: round-robin Wishbone B4 arbiter that shares the SDRAM controller slave port.
// Optional stall watchdog (err on timeout) is compiled in with WB_SDRAM_ARBITER_TIMEOUT_EN.
module wb_sdram_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [3*NUM_MASTERS-1:0]  m_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  m_bte_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);
  localparam int N = NUM_MASTERS;

  if (N < 2 || N > 4) begin : g_bad_num_masters
    $error("wb_sdram_arbiter: NUM_MASTERS must be 2..4");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_sdram_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

  state_t       state_q, state_d;
  logic [1:0]   cur_q, cur_d;
  logic [1:0]   last_q, last_d;
  logic [N-1:0] grant_q, grant_d;
  logic [1:0]   pick;
  logic         own_cyc;
`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
  logic [15:0]  wdog_q, wdog_d;
`endif

  // First requester searching upward from last+1, wrapping modulo N.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [N-1:0] req);
    logic [1:0] win;
    logic       found;
    int         j;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(last) + i) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = 2'(j);
      end
    end
    return win;
  endfunction

  assign pick    = rr_pick(last_q, m_cyc_i);
  assign grant_o = grant_q;

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    own_cyc = 1'b0;
    m_dat_o = s_dat_i;
    m_ack_o = '0;
    m_err_o = '0;
    for (int k = 0; k < N; k++) begin
      if (cur_q == 2'(k)) begin
        own_cyc = m_cyc_i[k];
        if (state_q == BUSY) begin
          s_adr_o = m_adr_i[32*k +: 32];
          s_dat_o = m_dat_i[32*k +: 32];
          s_sel_o = m_sel_i[4*k +: 4];
          s_we_o  = m_we_i[k];
          s_cyc_o = m_cyc_i[k];
          s_stb_o = m_stb_i[k];
          s_cti_o = m_cti_i[3*k +: 3];
          s_bte_o = m_bte_i[2*k +: 2];
        end
      end
    end
    if (state_q == BUSY) begin
      m_ack_o = grant_q & {N{s_ack_i}};
      m_err_o = grant_q & {N{s_err_i}};
    end
`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
    if (state_q == ABORT) m_err_o = grant_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    grant_d = grant_q;
`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
    wdog_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = BUSY;
          cur_d   = pick;
          last_d  = pick;
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
        else if (s_stb_o && !s_ack_i && !s_err_i) begin
          // This cycle is stall number wdog_q+1.
          if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) state_d = ABORT;
          else                                   wdog_d  = wdog_q + 16'd1;
        end
      end
      ABORT: begin
        // last stays on the aborted owner so the others win next.
        state_d = IDLE;
        grant_d = '0;
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= 2'(N - 1);
      grant_q <= '0;
`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      grant_q <= grant_d;
`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb_wb_sdram_arbiter: directed test-plan scenarios plus random traffic against a
// cycle-level ownership model of the arbiter.
module tb_wb_sdram_arbiter;
  localparam int N  = 3;
  localparam int TO = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [32*N-1:0]  m_adr_i, m_dat_i;
  logic [4*N-1:0]   m_sel_i;
  logic [N-1:0]     m_we_i, m_cyc_i, m_stb_i;
  logic [3*N-1:0]   m_cti_i;
  logic [2*N-1:0]   m_bte_i;
  logic [31:0]      m_dat_o;
  logic [N-1:0]     m_ack_o, m_err_o, grant_o;
  logic [31:0]      s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]       s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner index (-1 = nobody), last winner, abort flag, stall count.
  int mdl_owner = -1;
  int mdl_last  = N - 1;
  int mdl_stall = 0;
  bit mdl_abort = 1'b0;

  wb_sdram_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [N-1:0] onehot;
    bit           active;
    active = (mdl_owner >= 0) && !mdl_abort;
    onehot = '0;
    if (mdl_owner >= 0) onehot[mdl_owner] = 1'b1;
    check("grant", 64'(grant_o), 64'(onehot));
    check("m_dat", 64'(m_dat_o), 64'(s_dat_i));
    check("m_ack", 64'(m_ack_o), (active && s_ack_i) ? 64'(onehot) : 64'd0);
    check("m_err", 64'(m_err_o), ((active && s_err_i) || mdl_abort) ? 64'(onehot) : 64'd0);
    if (active) begin
      check("s_adr", 64'(s_adr_o), 64'(m_adr_i[32*mdl_owner +: 32]));
      check("s_dat", 64'(s_dat_o), 64'(m_dat_i[32*mdl_owner +: 32]));
      check("s_sel", 64'(s_sel_o), 64'(m_sel_i[4*mdl_owner +: 4]));
      check("s_ctl", 64'({s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o}),
            64'({m_we_i[mdl_owner], m_cyc_i[mdl_owner], m_stb_i[mdl_owner],
                 m_cti_i[3*mdl_owner +: 3], m_bte_i[2*mdl_owner +: 2]}));
    end else begin
      check("s_idle", 64'({s_adr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o}), 64'd0);
      check("s_idle_dat", 64'(s_dat_o), 64'd0);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      mdl_owner = -1; mdl_last = N - 1; mdl_abort = 1'b0; mdl_stall = 0;
    end else if (mdl_abort) begin
      mdl_abort = 1'b0; mdl_owner = -1;
    end else if (mdl_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        if (mdl_owner < 0 && m_cyc_i[(mdl_last + i) % N]) begin
          mdl_owner = (mdl_last + i) % N;
          mdl_last  = mdl_owner;
        end
      end
      mdl_stall = 0;
    end else if (!m_cyc_i[mdl_owner]) begin
      mdl_owner = -1; mdl_stall = 0;
    end else begin
`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
      if (m_stb_i[mdl_owner] && !s_ack_i && !s_err_i) begin
        mdl_stall++;
        if (mdl_stall == TO) begin mdl_abort = 1'b1; mdl_stall = 0; end
      end else mdl_stall = 0;
`endif
    end
  endtask

  // Check the current cycle, advance the model, return 1 time unit after the next edge.
  task automatic tick();
    @(negedge clock);
    model_check();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
    m_cti_i = '0; m_bte_i = '0; s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < N; k++) begin
      if (!m_cyc_i[k]) m_cyc_i[k] = ($urandom_range(3) == 0);
      else if ($urandom_range(7) == 0) m_cyc_i[k] = 1'b0;
      m_stb_i[k]          = m_cyc_i[k] & 1'($urandom_range(1));
      m_we_i[k]           = 1'($urandom_range(1));
      m_adr_i[32*k +: 32] = $urandom;
      m_dat_i[32*k +: 32] = $urandom;
      m_sel_i[4*k +: 4]   = 4'($urandom_range(15));
      m_cti_i[3*k +: 3]   = 3'($urandom_range(7));
      m_bte_i[2*k +: 2]   = 2'($urandom_range(3));
    end
    s_dat_i = $urandom;
    s_ack_i = 1'($urandom_range(1));
    s_err_i = ($urandom_range(15) == 0);
    reset   = ($urandom_range(199) == 0);
  endtask

  initial begin
    int acks0, acks1, stalls, n;
    logic [N-1:0] owner_oh;
    reset = 1'b1;
    clear_inputs();
    @(posedge clock);
    #1;
    tick();
    reset = 1'b0;

    // Idle after reset
    repeat (10) tick();
    check("idle_grant", 64'(grant_o), 64'd0);
    check("idle_scyc", 64'(s_cyc_o), 64'd0);

    // Simultaneous request: master 0 first, one dead cycle, then master 1
    m_cyc_i[1:0] = 2'b11; m_stb_i[1:0] = 2'b11;
    #1 check("req_no_grant_yet", 64'(grant_o), 64'd0);
    tick();
    check("first_grant", 64'(grant_o), 64'b001);
    check("first_scyc", 64'(s_cyc_o), 64'd1);
    repeat (2) tick();
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
    #1 check("release_scyc", 64'(s_cyc_o), 64'd0);
    tick();
    check("dead_cycle", 64'(grant_o), 64'd0);
    tick();
    check("second_grant", 64'(grant_o), 64'b010);

    // Master 1 8-beat incrementing burst, master 0 requests mid-burst
    acks0 = 0; acks1 = 0;
    for (int i = 0; i < 8; i++) begin
      m_adr_i[32 +: 32] = 32'h0000_0100 + 32'(4 * i);
      m_cti_i[3 +: 3]   = (i == 7) ? 3'b111 : 3'b010;
      m_stb_i[1] = 1'b1;
      s_ack_i    = 1'b1;
      if (i == 3) begin m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; end
      #1;
      if (m_ack_o[1]) acks1++;
      if (m_ack_o[0]) acks0++;
      tick();
    end
    m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0; m_cti_i = '0; s_ack_i = 1'b0;
    check("burst_acks_m1", 64'(acks1), 64'd8);
    check("burst_acks_m0", 64'(acks0), 64'd0);
    tick();
    tick();
    check("after_burst_grant", 64'(grant_o), 64'b001);

    // Read data broadcast with ack only to the owner
    m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_we_i = '0;
    s_dat_i = 32'hDEAD_BEEF; s_ack_i = 1'b1;
    #1;
    check("read_data", 64'(m_dat_o), 64'hDEAD_BEEF);
    check("read_ack", 64'(m_ack_o), 64'b001);
    tick();
    s_ack_i = 1'b0;

    // Reset mid-burst
    m_cti_i[0 +: 3] = 3'b010;
    reset = 1'b1;
    tick();
    check("reset_scyc", 64'(s_cyc_o), 64'd0);
    check("reset_grant", 64'(grant_o), 64'd0);
    reset = 1'b0;
    tick();
    check("post_reset_grant", 64'(grant_o), 64'b001);

`ifdef WB_SDRAM_ARBITER_TIMEOUT_EN
    // Watchdog: never-acking slave
    clear_inputs();
    tick();
    tick();
    m_cyc_i[1:0] = 2'b11; m_stb_i[1:0] = 2'b11;
    tick();
    owner_oh = grant_o;
    stalls = 0; n = 0;
    while (m_err_o == '0 && n < 60) begin
      if (s_stb_o) stalls++;
      tick();
      n++;
    end
    check("to_stalls", 64'(stalls), 64'(TO));
    check("to_err_owner", 64'(m_err_o), 64'(owner_oh));
    check("to_abort_scyc", 64'(s_cyc_o), 64'd0);
    tick();
    check("to_err_pulse", 64'(m_err_o), 64'd0);
    tick();
    check("to_next_grant", 64'(grant_o), 64'(owner_oh == 3'b001 ? 3'b010 : 3'b001));
`endif

    // Random traffic against the model
    clear_inputs();
    repeat (2000) begin
      rand_inputs();
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
